hello_vlog: RTL and testbench
=============================

Name: hello_vlog

Overview:
Registered dual-bus parity/XOR reducer. Each cycle it XOR-reduces two independent input buses, A_in and B_in, to one bit each. Sel_in selects true parity (XOR) or inverted parity (XNOR). Results are registered on Clock. Used as a minimal bring-up block: clock/reset sanity, bench plumbing, waveform dump checks.

Parameters:
WIDTH, 2, bit width of A_in and B_in; legal range 1 to 64.

Ports:
Clock  input  1  rising-edge system clock.
Reset_n  input  1  synchronous active-low reset, sampled on rising Clock.
A_in  input  WIDTH  operand bus A.
B_in  input  WIDTH  operand bus B.
Sel_in  input  1  0 = XOR reduction (odd parity), 1 = XNOR reduction (inverted parity); applies to both buses.
A_xor_out  output  1  registered reduction result of A_in.
B_xor_out  output  1  registered reduction result of B_in.

Behaviour:
- One clock domain (Clock). Reset is synchronous and active-low (Reset_n). No asynchronous reset path.
- Reset:
  - On any rising Clock edge with Reset_n = 0: A_xor_out <= 0 and B_xor_out <= 0.
  - Reset has priority over all other inputs.
- Outputs are undefined only before the first clock edge. The bench holds reset for at least 1 cycle.
- Function, on a rising edge with Reset_n = 1:
  - A_xor_out <= (XOR of all bits of A_in) XOR Sel_in.
  - B_xor_out <= (XOR of all bits of B_in) XOR Sel_in.
- Latency: exactly 1 cycle. Inputs are sampled on edge N; the result is visible after edge N and holds until edge N+1.
- No combinational path from any input to any output. Both outputs come straight from flops.
- A and B paths are fully independent apart from the shared Sel_in. Sel_in changing in a cycle affects both outputs at the same edge.
- Reset mid-operation: asserting Reset_n = 0 while inputs are nonzero forces both outputs to 0 at the next edge and holds them there while reset is low.
- Reset release: first functional update at the first rising edge sampling Reset_n = 1.
- X/Z on inputs is not required to be handled; the bench drives only 0/1.
- WIDTH = 1 degenerates to a registered copy of the bit (Sel_in = 0) or its inverse (Sel_in = 1).
- Reference for WIDTH = 2, Sel_in = 0:
  - 00 -> 0
  - 01 -> 1
  - 10 -> 1
  - 11 -> 0
- With Sel_in = 1 the same table is inverted.
- Implementation: flops plus reduction logic only. No latches, no initial values relied on for function.

Test Plan:
1. Reset: Reset_n = 0 for 2 cycles, A_in = 00, B_in = 00, Sel_in = 0 -> both outputs 0 after the first edge and stay 0.
2. XOR mode: release reset, then Sel_in = 0, A_in = 01, B_in = 10 -> after 1 edge A_xor_out = 1, B_xor_out = 1; stable for 5 cycles.
3. XNOR mode: Sel_in = 1, A_in = 00, B_in = 11 -> after 1 edge A_xor_out = 1, B_xor_out = 1. With Sel_in = 1, A_in = 01, B_in = 11 -> A_xor_out = 0, B_xor_out = 1.
4. Latency/independence: sweep all 16 A_in/B_in pairs for each Sel_in -> each output equals the predicted reduction of inputs sampled on the previous edge. A and B never cross-couple.
5. Mid-run reset: in XNOR mode with outputs at 1, drive Reset_n = 0 for 5 cycles -> both outputs 0 at the next edge and throughout. On release, outputs resume the correct function 1 edge later.
6. No combinational path: toggle A_in, B_in and Sel_in between edges -> outputs change only at rising Clock edges.

Source files
------------

// File: rtl/hello_vlog.sv
// hello_vlog: registered dual-bus parity reducer.
// Each cycle both operand buses are XOR-reduced to a single bit. Sel_in
// optionally inverts both results (XNOR reduction). Results are registered
// on Clock, so outputs come straight from flops with one cycle of latency.
//
// Ports:
//   Clock      rising-edge system clock
//   Reset_n    synchronous active-low reset; clears both outputs
//   A_in       operand bus A, WIDTH bits
//   B_in       operand bus B, WIDTH bits
//   Sel_in     0 = odd parity (XOR), 1 = inverted parity (XNOR), both buses
//   A_xor_out  registered reduction of A_in
//   B_xor_out  registered reduction of B_in
module hello_vlog #(
  parameter int unsigned WIDTH = 2  // legal range 1..64
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Sel_in,
  output logic             A_xor_out,
  output logic             B_xor_out
);

  logic a_par;
  logic b_par;

  // Bitwise parity fold; Sel_in seeds the accumulator so the inversion
  // is folded into the same XOR chain.
  always_comb begin
    a_par = Sel_in;
    b_par = Sel_in;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      a_par = a_par ^ A_in[i];
      b_par = b_par ^ B_in[i];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      A_xor_out <= 1'b0;
      B_xor_out <= 1'b0;
    end else begin
      A_xor_out <= a_par;
      B_xor_out <= b_par;
    end
  end

endmodule

// File: tb/tb_hello_vlog.sv
// Directed self-checking bench for hello_vlog (WIDTH = 2 and WIDTH = 1).
module tb_hello_vlog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] a;
  logic [1:0] b;
  logic       sel;
  logic       a_out;
  logic       b_out;
  logic       a1;
  logic       b1;
  logic       a1_out;
  logic       b1_out;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Hand-computed parity of a 2-bit value: 00->0, 01->1, 10->1, 11->0
  logic [3:0] ptab = 4'b0110;

  always #5 clk = ~clk;

  hello_vlog #(.WIDTH(2)) u_dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .A_in      (a),
    .B_in      (b),
    .Sel_in    (sel),
    .A_xor_out (a_out),
    .B_xor_out (b_out)
  );

  hello_vlog #(.WIDTH(1)) u_w1 (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .A_in      (a1),
    .B_in      (b1),
    .Sel_in    (sel),
    .A_xor_out (a1_out),
    .B_xor_out (b1_out)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a = 2'b00; b = 2'b00; sel = 1'b0; a1 = 1'b0; b1 = 1'b0;

    // 1. reset for 2 cycles
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_a", a_out, 1'b0);
      check("rst_b", b_out, 1'b0);
      check("rst_w1_a", a1_out, 1'b0);
      check("rst_w1_b", b1_out, 1'b0);
    end

    // 2. XOR mode, stable over 5 cycles
    rst_n = 1'b1; sel = 1'b0; a = 2'b01; b = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      check("xor_a", a_out, 1'b1);
      check("xor_b", b_out, 1'b1);
    end

    // 3. XNOR mode
    sel = 1'b1; a = 2'b00; b = 2'b11;
    step();
    check("xnor1_a", a_out, 1'b1);
    check("xnor1_b", b_out, 1'b1);
    a = 2'b01; b = 2'b11;
    step();
    check("xnor2_a", a_out, 1'b0);
    check("xnor2_b", b_out, 1'b1);

    // 4. full sweep of A/B pairs for both Sel values, plus WIDTH=1 instance
    for (int s = 0; s < 2; s++) begin
      for (int ai = 0; ai < 4; ai++) begin
        for (int bi = 0; bi < 4; bi++) begin
          sel = s[0];
          a   = 2'(ai);
          b   = 2'(bi);
          a1  = a[0];
          b1  = b[1];
          step();
          check("sweep_a", a_out, ptab[a] ^ s[0]);
          check("sweep_b", b_out, ptab[b] ^ s[0]);
          check("w1_a", a1_out, a[0] ^ s[0]);
          check("w1_b", b1_out, b[1] ^ s[0]);
        end
      end
    end

    // 5. mid-run reset while outputs are 1 in XNOR mode
    sel = 1'b1; a = 2'b00; b = 2'b11;
    step();
    check("pre_rst_a", a_out, 1'b1);
    check("pre_rst_b", b_out, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_rst_a", a_out, 1'b0);
      check("mid_rst_b", b_out, 1'b0);
    end
    rst_n = 1'b1;
    step();
    check("post_rst_a", a_out, 1'b1);
    check("post_rst_b", b_out, 1'b1);

    // 6. inputs toggling between edges must not reach the outputs
    sel = 1'b0; a = 2'b01; b = 2'b00;
    step();
    check("comb0_a", a_out, 1'b1);
    check("comb0_b", b_out, 1'b0);
    #2;
    a = 2'b00; b = 2'b01; sel = 1'b1;
    #1;
    check("comb1_a", a_out, 1'b1);
    check("comb1_b", b_out, 1'b0);
    a = 2'b11;
    #1;
    check("comb2_a", a_out, 1'b1);
    check("comb2_b", b_out, 1'b0);
    step();
    check("comb3_a", a_out, 1'b1);
    check("comb3_b", b_out, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
